// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - 4-channel DMA request qualifier, priority arbiter and DACK driver
// Latches one winning channel per service cycle and keeps sticky terminal-count flags.
module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              rotatePriority,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic              cycleStart,
  input  logic              assertDACK,
  input  logic              transferDone,
  input  logic              eop,
  input  logic              statusRead,
  output logic              reqPending,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantChannel,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] tcStatus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    GRANT  = 3'b010,
    UPDATE = 3'b100
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   prioPtr;
  logic              eopSeen;
  logic [NUM_CH-1:0] effReq;
  logic              anyReq;
  logic [CH_W-1:0]   startCh;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   winner;
  logic              found;
  logic [CH_W-1:0]   nextPtr;
  logic [NUM_CH-1:0] tcSet;

  always_comb begin
    effReq = ((DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | requestReg;
    anyReq = |effReq;
  end

  // Scan from the highest-priority channel upward, wrapping; first requester wins.
  always_comb begin
    startCh = rotatePriority ? prioPtr : '0;
    winner  = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(startCh) + i) % NUM_CH);
      if (!found && effReq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    nextPtr = CH_W'((int'(grantChannel) + 1) % NUM_CH);
    tcSet   = NUM_CH'(1) << grantChannel;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      reqPending   <= 1'b0;
      grantValid   <= 1'b0;
      grantChannel <= '0;
      prioPtr      <= '0;
      tcStatus     <= '0;
      eopSeen      <= 1'b0;
    end else begin
      reqPending <= anyReq;
      if (statusRead) tcStatus <= '0;
      case (state)
        IDLE: begin
          if (cycleStart && anyReq) begin
            grantChannel <= winner;
            grantValid   <= 1'b1;
            reqPending   <= 1'b0;
            state        <= GRANT;
          end
        end
        GRANT: begin
          reqPending <= 1'b0;
          if (transferDone) begin
            eopSeen <= eop;
            state   <= UPDATE;
          end
        end
        UPDATE: begin
          // grantValid drops with this edge, so reqPending may be raised again here.
          if (rotatePriority) prioPtr <= nextPtr;
          if (eopSeen) tcStatus <= (statusRead ? '0 : tcStatus) | tcSet;
          grantValid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          grantValid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    DACK = {NUM_CH{~dackActiveHigh}};
    if (state == GRANT && assertDACK) DACK[grantChannel] = dackActiveHigh;
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - self-checking bench for dma_channel_arbiter
// Transaction-level model compared every cycle, plus directed literal expectations.
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic       dreqActiveLow = 1'b0;
  logic       dackActiveHigh = 1'b1;
  logic       rotatePriority = 1'b0;
  logic [3:0] maskReg = '0;
  logic [3:0] requestReg = '0;
  logic       cycleStart = 1'b0;
  logic       assertDACK = 1'b0;
  logic       transferDone = 1'b0;
  logic       eop = 1'b0;
  logic       statusRead = 1'b0;
  logic       reqPending;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [3:0] DACK;
  logic [3:0] tcStatus;

  int checks = 0;
  int failures = 0;

  dma_channel_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreqActiveLow(dreqActiveLow),
    .dackActiveHigh(dackActiveHigh), .rotatePriority(rotatePriority),
    .maskReg(maskReg), .requestReg(requestReg), .cycleStart(cycleStart),
    .assertDACK(assertDACK), .transferDone(transferDone), .eop(eop),
    .statusRead(statusRead), .reqPending(reqPending), .grantValid(grantValid),
    .grantChannel(grantChannel), .DACK(DACK), .tcStatus(tcStatus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a service is either absent, in progress (serving) or being closed (finishing).
  logic       m_rp = 1'b0, m_gv = 1'b0, m_serving = 1'b0, m_finishing = 1'b0, m_eop = 1'b0;
  int         m_gch = 0, m_ptr = 0;
  logic [3:0] m_tc = '0;
  logic [3:0] m_eff, m_tcn;

  function automatic int pick(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++)
      if (req[(start + k) % 4]) return (start + k) % 4;
    return 0;
  endfunction

  always @(posedge CLK) begin
    m_eff = ((dreqActiveLow ? ~DREQ : DREQ) & ~maskReg) | requestReg;
    if (RESET) begin
      m_rp = 0; m_gv = 0; m_serving = 0; m_finishing = 0; m_eop = 0;
      m_gch = 0; m_ptr = 0; m_tc = '0;
    end else begin
      m_tcn = statusRead ? 4'b0000 : m_tc;
      if (m_finishing) begin
        if (rotatePriority) m_ptr = (m_gch + 1) % 4;
        if (m_eop) m_tcn[m_gch] = 1'b1;
        m_gv = 0;
        m_finishing = 0;
      end else if (m_serving) begin
        if (transferDone) begin
          m_serving = 0;
          m_finishing = 1;
          m_eop = eop;
        end
      end else if (cycleStart && m_eff != 0) begin
        m_gch = pick(m_eff, rotatePriority ? m_ptr : 0);
        m_gv = 1;
        m_serving = 1;
      end
      m_tc = m_tcn;
      m_rp = (m_eff != 0) && !m_gv;
    end
  end

  logic [3:0] exp_dack;
  always @(negedge CLK) begin
    exp_dack = dackActiveHigh ? 4'b0000 : 4'b1111;
    if (m_serving && assertDACK) exp_dack[m_gch] = dackActiveHigh;
    chk("model_reqPending", reqPending, m_rp);
    chk("model_grantValid", grantValid, m_gv);
    if (m_gv) chk("model_grantChannel", grantChannel, m_gch);
    chk("model_DACK", DACK, exp_dack);
    chk("model_tcStatus", tcStatus, m_tc);
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  // Full service cycle; a cycleStart alongside transferDone must be dropped.
  task automatic serve(input int exp_ch, input logic e, input logic sr);
    cycleStart = 1; cyc(); cycleStart = 0;
    chk("serve_grantValid", grantValid, 1);
    chk("serve_grantChannel", grantChannel, exp_ch);
    cyc();
    transferDone = 1; eop = e; statusRead = sr; cycleStart = 1;
    cyc();
    transferDone = 0; eop = 0; statusRead = 0; cycleStart = 0;
    cyc();
    chk("serve_released", grantValid, 0);
  endtask

  initial begin
    cyc(); cyc();
    chk("reset_reqPending", reqPending, 0);
    chk("reset_grantValid", grantValid, 0);
    chk("reset_grantChannel", grantChannel, 0);
    chk("reset_tcStatus", tcStatus, 0);
    chk("reset_DACK", DACK, 4'b0000);
    RESET = 0;
    cyc();

    // withdrawn request: cycleStart with nothing pending
    cycleStart = 1; cyc(); cycleStart = 0;
    chk("withdrawn_grantValid", grantValid, 0);

    // fixed priority
    DREQ = 4'b1010; cyc();
    serve(1, 0, 0);

    // rotating priority
    rotatePriority = 1; DREQ = 4'b1111;
    for (int c = 0; c < 4; c++) serve(c, 0, 0);
    DREQ = 4'b0101;
    serve(0, 0, 0);

    // mask and software request
    rotatePriority = 0; DREQ = 4'b0001; maskReg = 4'b0001;
    cyc(); cyc();
    chk("masked_reqPending", reqPending, 0);
    requestReg = 4'b0100; cyc();
    chk("swreq_reqPending", reqPending, 1);
    serve(2, 0, 0);
    requestReg = '0; maskReg = '0;

    // polarity
    dreqActiveLow = 1; dackActiveHigh = 0; DREQ = 4'b1110;
    cycleStart = 1; cyc(); cycleStart = 0;
    chk("pol_grantChannel", grantChannel, 0);
    assertDACK = 1; #1;
    chk("pol_DACK", DACK, 4'b1110);
    cyc();
    assertDACK = 0; transferDone = 1; cyc(); transferDone = 0; cyc();
    dreqActiveLow = 0; dackActiveHigh = 1;

    // terminal count
    DREQ = 4'b0100; serve(2, 1, 0);
    chk("eop_tc_ch2", tcStatus, 4'b0100);
    DREQ = 4'b0010; serve(1, 1, 1);
    chk("eop_tc_read_ch1", tcStatus, 4'b0010);

    // reset mid-grant after moving the rotating pointer
    rotatePriority = 1; DREQ = 4'b0010; serve(1, 0, 0);
    DREQ = 4'b1000;
    cycleStart = 1; cyc(); cycleStart = 0;
    assertDACK = 1; #1;
    chk("midgrant_DACK", DACK, 4'b1000);
    RESET = 1; cyc();
    chk("midreset_grantValid", grantValid, 0);
    chk("midreset_DACK", DACK, 4'b0000);
    chk("midreset_tcStatus", tcStatus, 0);
    RESET = 0; assertDACK = 0; cyc();
    DREQ = 4'b0110;
    serve(1, 0, 0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
